// File: rtl/spi_apb_initiator_pkg.sv
// Shared types for the SPI APB initiator: request/response records and FSM states.
package spi_apb_initiator_pkg;

  localparam int unsigned SPI_PADDR_WIDTH = 5;
  localparam int unsigned SPI_DATA_WIDTH  = 32;

  typedef struct packed {
    logic                      write;
    logic [SPI_PADDR_WIDTH-1:0] addr;
    logic [SPI_DATA_WIDTH-1:0]  wdata;
    logic [3:0]                strb;
    logic [2:0]                prot;
  } apb_req_type;

  typedef struct packed {
    logic [SPI_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_type;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_mst_state;

endpackage

// File: rtl/spi_apb_cmd_fifo.sv
// Synchronous command FIFO of apb_req_type; extra pointer MSB separates full from empty.
module spi_apb_cmd_fifo
  import spi_apb_initiator_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        i_push,
  input  apb_req_type i_data,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_empty,
  output apb_req_type o_head
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  apb_req_type r_mem [CMD_DEPTH];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop && !o_empty)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (i_push && !o_full)
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_apb_initiator.sv
// APB initiator for the SPI register port: command FIFO, SETUP/ACCESS sequencing, one response per command.
// Optional ACCESS-phase watchdog enabled by defining SPI_APB_TIMEOUT_EN.
module spi_apb_initiator
  import spi_apb_initiator_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [4:0]  paddr,
  output logic [2:0]  pprot,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  apb_mst_state r_state, w_state_next;
  apb_req_type  w_req, w_head, r_apb;
  apb_rsp_type  w_rsp_next, r_rsp;
  logic         r_rsp_valid;
  logic         w_full, w_empty, w_push, w_pop, w_load, w_rsp_load, w_timeout;

  assign w_req     = {req_write, req_addr, req_wdata, req_strb, req_prot};
  assign req_ready = !w_full && !preset;
  assign w_push    = req_valid && req_ready;

  spi_apb_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .pclk    (pclk),
    .preset  (preset),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef SPI_APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)
      r_wait_cnt <= '0;
    else if (r_state == SETUP)
      r_wait_cnt <= '0;
    else if (r_state == ACCESS && !pready)
      r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
  end

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; pready in that cycle still wins.
  assign w_timeout = (r_state == ACCESS) && !pready &&
                     (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_rsp_load   = 1'b0;
    w_rsp_next   = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty && (!r_rsp_valid || rsp_ready)) begin
          w_state_next = SETUP;
          w_load       = 1'b1;
        end
      end
      SETUP: w_state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          w_state_next     = IDLE;
          w_pop            = 1'b1;
          w_rsp_load       = 1'b1;
          w_rsp_next.rdata = r_apb.write ? '0 : prdata;
          w_rsp_next.err   = pslverr;
        end else if (w_timeout) begin
          w_state_next       = IDLE;
          w_pop              = 1'b1;
          w_rsp_load         = 1'b1;
          w_rsp_next.err     = 1'b1;
          w_rsp_next.timeout = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)      r_apb <= '0;
    else if (w_load) r_apb <= w_head;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
    end else if (w_rsp_load) begin
      r_rsp       <= w_rsp_next;
      r_rsp_valid <= 1'b1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign psel        = (r_state != IDLE);
  assign penable     = (r_state == ACCESS);
  assign pwrite      = r_apb.write;
  assign paddr       = r_apb.addr;
  assign pwdata      = r_apb.wdata;
  assign pstrb       = r_apb.strb;
  assign pprot       = r_apb.prot;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp.rdata;
  assign rsp_err     = r_rsp.err;
  assign rsp_timeout = r_rsp.timeout;
  assign busy        = (r_state != IDLE) || !w_empty || r_rsp_valid;

endmodule

// File: tb/tb_spi_apb_initiator.sv
// Self-checking bench for spi_apb_initiator: directed steps plus randomized transfers against a transaction-level model.
module tb_spi_apb_initiator;

  logic        pclk, preset;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        w;
    logic [4:0]  a;
    logic [31:0] wd;
  } tb_cmd_t;

  tb_cmd_t exp_q[$];

  spi_apb_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave read data as a pure function of the address, so responses identify their command.
  function automatic logic [31:0] rd_of(input logic [4:0] a);
    return 32'h1357_9BDF ^ {a, a, a, a, a, a, 2'b00};
  endfunction

  task automatic drive_req(input logic w, input logic [4:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr);
    req_write = w; req_addr = a; req_wdata = wd; req_strb = st; req_prot = pr;
    req_valid = 1'b1;
  endtask

  // One isolated transfer: exact cycle-by-cycle APB timing and the response contents.
  task automatic run_one(input logic w, input logic [4:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr,
                         input int unsigned waits, input logic er, input logic [31:0] rd);
    logic [31:0] exp_rd;
    exp_rd = w ? 32'h0 : rd;
    drive_req(w, a, wd, st, pr);
    check("idle_req_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    check("accept_psel", psel, 0);
    check("accept_busy", busy, 1);
    tick;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_pwrite", pwrite, w);
    check("setup_paddr", paddr, a);
    check("setup_pwdata", pwdata, wd);
    check("setup_pstrb", pstrb, st);
    check("setup_pprot", pprot, pr);
    check("setup_rsp_valid", rsp_valid, 0);
    tick;
    for (int unsigned k = 0; k < waits; k++) begin
      check("wait_penable", penable, 1);
      check("wait_paddr", paddr, a);
      check("wait_pwdata", pwdata, wd);
      check("wait_rsp_valid", rsp_valid, 0);
      pready = 1'b0; pslverr = 1'b1; prdata = $urandom;
      tick;
    end
    check("last_psel", psel, 1);
    check("last_penable", penable, 1);
    check("last_paddr", paddr, a);
    pready = 1'b1; pslverr = er; prdata = rd;
    tick;
    pready = 1'b0; pslverr = 1'b0;
    check("done_psel", psel, 0);
    check("done_rsp_valid", rsp_valid, 1);
    check("done_rsp_rdata", rsp_rdata, exp_rd);
    check("done_rsp_err", rsp_err, er);
    check("done_rsp_timeout", rsp_timeout, 0);
    check("done_busy", busy, 1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("consumed_rsp_valid", rsp_valid, 0);
    check("consumed_busy", busy, 0);
  endtask

  initial begin
    int accepted, produced;
    logic acc_now;
    tb_cmd_t c, e, pend;

    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) tick;
    check("rst_req_ready", req_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pprot", pprot, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    preset = 1'b0;
    #1;
    check("post_rst_req_ready", req_ready, 1);
    tick;

    // Zero-wait write, then a read with three wait states.
    run_one(1'b1, 5'h04, 32'h0000_00A5, 4'hF, 3'h0, 0, 1'b0, $urandom);
    run_one(1'b0, 5'h08, $urandom, 4'hF, 3'h0, 3, 1'b0, 32'h1234_5678);
    // Slave error on a read; pslverr held high through the wait states beforehand.
    run_one(1'b0, 5'h0C, $urandom, 4'h3, 3'h2, 2, 1'b1, 32'h0);
    run_one(1'b0, 5'h10, $urandom, 4'h1, 3'h1, 2, 1'b0, 32'hCAFE_F00D);

    for (int i = 0; i < 8; i++) begin
      logic w, er;
      w  = 1'($urandom_range(0, 1));
      er = 1'($urandom_range(0, 1));
      run_one(w, 5'($urandom), $urandom, 4'($urandom), 3'($urandom),
              $urandom_range(0, 3), er, (er && !w) ? 32'h0 : $urandom);
    end

    // Fill the FIFO with the slave stalled, then drain in order.
    pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b1;
    accepted = 0; produced = 0;
    for (int i = 0; i < 4; i++) begin
      c.w = (i % 2 == 0); c.a = 5'(i * 3 + 1); c.wd = $urandom;
      drive_req(c.w, c.a, c.wd, 4'hF, 3'h0);
      check("fill_req_ready", req_ready, 1);
      tick;
      exp_q.push_back(c);
      accepted++;
    end
    pend.w = 1'b0; pend.a = 5'h1D; pend.wd = $urandom;
    drive_req(pend.w, pend.a, pend.wd, 4'hF, 3'h0);
    check("full_req_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_req_ready", req_ready, 0);
      check("stall_penable", penable, 1);
      check("stall_rsp_valid", rsp_valid, 0);
    end
    for (int cyc = 0; cyc < 100 && produced < 5; cyc++) begin
      pready = 1'b1;
      prdata = rd_of(paddr);
      check("drain_req_ready", req_ready, ((accepted - produced) < 4) ? 1 : 0);
      acc_now = req_valid && req_ready;
      tick;
      if (acc_now) begin
        exp_q.push_back(pend);
        accepted++;
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("drain_unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("drain_rsp_rdata", rsp_rdata, e.w ? 32'h0 : rd_of(e.a));
          check("drain_rsp_err", rsp_err, 0);
        end
        produced++;
      end
    end
    check("drain_count", produced, 5);
    pready = 1'b0;
    tick;
    check("drain_busy", busy, 0);
    rsp_ready = 1'b0;

    // Reset pulsed during ACCESS with two commands queued.
    drive_req(1'b1, 5'h02, $urandom, 4'hF, 3'h0);
    tick;
    drive_req(1'b0, 5'h03, $urandom, 4'hF, 3'h0);
    tick;
    req_valid = 1'b0;
    tick;
    check("pre_rst_penable", penable, 1);
    #2 preset = 1'b1;
    #1;
    check("async_rst_psel", psel, 0);
    check("async_rst_penable", penable, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_req_ready", req_ready, 0);
    @(negedge pclk);
    preset = 1'b0;
    #1;
    check("rel_req_ready", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rel_psel", psel, 0);
      check("rel_rsp_valid", rsp_valid, 0);
      check("rel_busy", busy, 0);
    end

`ifdef SPI_APB_TIMEOUT_EN
    begin
      int acc_cycles;
      logic got;
      acc_cycles = 0; got = 1'b0;
      pready = 1'b0;
      drive_req(1'b0, 5'h14, 32'h0, 4'hF, 3'h0);
      tick;
      req_valid = 1'b0;
      prdata = 32'hFFFF_FFFF;
      for (int cyc = 0; cyc < 60 && !got; cyc++) begin
        tick;
        if (rsp_valid) got = 1'b1;
        else if (penable) acc_cycles++;
      end
      check("to_rsp_seen", got, 1);
      check("to_access_cycles", acc_cycles, 16);
      check("to_psel", psel, 0);
      check("to_rsp_err", rsp_err, 1);
      check("to_rsp_timeout", rsp_timeout, 1);
      check("to_rsp_rdata", rsp_rdata, 0);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("to_consumed", rsp_valid, 0);
      run_one(1'b0, 5'h18, 32'h0, 4'hF, 3'h0, 15, 1'b0, 32'hA5A5_5A5A);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_apb_initiator.md
# spi_apb_initiator

APB initiator that drives the SPI peripheral's register port (paddr width 5, 32-bit data) from a simple valid/ready command stream. It buffers commands in a small FIFO, sequences each one through the APB SETUP and ACCESS phases, and waits on pready. It returns one response per command, carrying read data, slave error and timeout status. The block sits between the SoC-side controller (CPU shim or DMA) and the SPI APB slave.

## Interface
- CMD_DEPTH, 4: command FIFO entries; power of 2, ≥2
- TIMEOUT_CYCLES, 16: ACCESS-phase wait cycles before abort; ≥1
- pclk  in  1  clock; all logic rising-edge
- preset  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  1  command valid
- req_ready  out  1  command FIFO not full; 0 while preset high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  5  register address
- req_wdata  in  32  write data
- req_strb  in  4  write byte strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes and aborted transfers
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- busy  out  1  state≠IDLE, or FIFO non-empty, or rsp_valid
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  5; pprot  out  3; pwdata  out  32; pstrb  out  4  APB request fields
- prdata  in  32; pready  in  1; pslverr  in  1  APB completion

## Operation
- Command accepted on a clock edge where req_valid & req_ready; it is pushed into the FIFO as {write, addr, wdata, strb, prot}.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE: psel=0, penable=0. Go to SETUP when the FIFO is non-empty and the response slot is free (!rsp_valid | rsp_ready); load paddr/pwrite/pwdata/pstrb/pprot from the FIFO head.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. The APB request fields stay stable throughout.
  - On pready=1: register the response (rsp_rdata=prdata for reads, 0 for writes; rsp_err=pslverr; rsp_timeout=0), set rsp_valid, pop the FIFO, go to IDLE.
  - pslverr is ignored while pready=0.
- Response slot: single entry. rsp_valid clears on rsp_valid & rsp_ready unless a new response loads in the same edge. A new response cannot load in that edge by construction: a transfer only starts once the slot is free.
- APB request fields hold their last values in IDLE; psel gates their meaning.
- FIFO full: req_ready=0, the FIFO is untouched, and the pending command waits.
- Simultaneous push and pop on a full FIFO is not allowed, because req_ready is already 0. On a non-full FIFO, push and pop in the same cycle leave the count unchanged.
- Pointers are log2(CMD_DEPTH)+1 bits wide; full/empty is decided by the MSB compare on wrap-around.

## Timing
- Reset values: psel, penable, pwrite, paddr, pprot, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0; busy=0; state=IDLE; FIFO empty.
- preset asserted mid-transfer: psel/penable drop asynchronously and the command is lost. No response is produced.
- Zero wait states: accept at edge N, then psel=1 after N+1, penable=1 after N+2, rsp_valid=1 after N+3.
- Each wait state (pready=0 in ACCESS) adds one cycle.
- Minimum spacing between transfers: 3 cycles (SETUP, ACCESS, IDLE).

## Configuration
- SPI_APB_TIMEOUT_EN defined: a wait counter runs in ACCESS, cleared on entry to SETUP.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer aborts: psel/penable go to 0 next edge, response loads with rsp_rdata=0, rsp_err=1, rsp_timeout=1, the FIFO pops, and the FSM returns to IDLE.
  - If pready=1 arrives in the last counted cycle, normal completion takes priority.
- SPI_APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0.

## Structure
- SPI_package gains:
  - apb_req_type struct {write, addr[SPI_PADDR_WIDTH], wdata bus, strb[4], prot[3]}
  - apb_rsp_type struct {rdata bus, err, timeout}
  - enum apb_mst_state {IDLE, SETUP, ACCESS}
- The existing apb_interfaces_in/out field widths are reused.
- Sub-module spi_apb_cmd_fifo: synchronous FIFO of apb_req_type, parameter CMD_DEPTH, with outputs full, empty and head.

## Test plan
- Write 0x0000_00A5 to addr 0x04, pready tied 1 -> one SETUP and one ACCESS cycle with pwrite=1, pwdata=0xA5, pstrb=0xF; rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Read addr 0x08, pready low 3 cycles, prdata=0x1234_5678 -> penable high 4 cycles with paddr stable; rsp_rdata=0x1234_5678.
- Push 5 commands with rsp_ready=1, CMD_DEPTH=4, APB stalled -> req_ready=0 after the 4th; all 5 complete in order once pready is released.
- pslverr=1 with pready=1 on a read -> rsp_err=1, rsp_timeout=0, rsp_rdata=0; pslverr=1 with pready=0 is ignored.
- SPI_APB_TIMEOUT_EN, pready stuck 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; the next command proceeds normally.
- preset pulsed during ACCESS with 2 commands queued -> psel=0 immediately, no response, busy=0, req_ready=1 after release.
